// File: rtl/fifo_serial_tx.sv
// Serializer draining a first-word-fall-through FIFO onto an idle-high line.
// Frame: start, 8 data bits LSB-first, optional even parity, stop.
module fifo_serial_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter bit PARITY_EN    = 1'b0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_rdata,
  output logic                 fifo_r_enable,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] bytes_sent
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 serial_out_q, serial_out_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [CNT_WIDTH-1:0] bytes_q, bytes_d;
  logic                 div_wrap;
  logic                 launch;

  always_comb begin
    div_wrap = (div_q == DIV_MAX);
    launch   = tx_en & ~fifo_empty & ~rst &
               ((state_q == S_IDLE) | ((state_q == S_STOP) & div_wrap));

    state_d  = state_q;
    div_d    = (state_q == S_IDLE || div_wrap) ? '0 : div_q + DIV_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bytes_d  = bytes_q;

    case (state_q)
      S_IDLE: ;
      S_START: begin
        if (div_wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (div_wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (div_wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (div_wrap) begin
          bytes_d = bytes_q + CNT_WIDTH'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A launch (from IDLE or the final stop cycle) overrides the case result.
    if (launch) begin
      state_d  = S_START;
      div_d    = '0;
      bit_d    = '0;
      shift_d  = fifo_rdata;
      parity_d = ^fifo_rdata;
    end

    case (state_d)
      S_START:  serial_out_d = 1'b0;
      S_DATA:   serial_out_d = shift_d[0];
      S_PARITY: serial_out_d = parity_d;
      default:  serial_out_d = 1'b1;
    endcase
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP) && (div_d == DIV_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      bytes_q      <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      bytes_q      <= bytes_d;
    end
  end

  assign fifo_r_enable = launch;
  assign serial_out    = serial_out_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign bytes_sent    = bytes_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench: dut0 (no parity, 16-bit count), dut1 (even parity, 4-bit count).
module tb_fifo_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic tx_en0, tx_en1, flush0;
  logic [7:0] mem0 [0:31];
  logic [7:0] mem1 [0:31];
  logic [5:0] wr0, wr1;
  logic [5:0] rd0 = '0;
  logic [5:0] rd1 = '0;
  logic fifo_empty0, fifo_empty1;
  logic [7:0] fifo_rdata0, fifo_rdata1;
  logic fifo_r_enable0, serial_out0, busy0, frame_done0;
  logic fifo_r_enable1, serial_out1, busy1, frame_done1;
  logic [15:0] bytes_sent0;
  logic [3:0] bytes_sent1;

  int pops0 = 0;
  int pops1 = 0;
  int fd1_cnt = 0;
  int fd1_dbl = 0;
  logic fd1_prev = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  assign fifo_empty0 = (rd0 == wr0);
  assign fifo_empty1 = (rd1 == wr1);
  assign fifo_rdata0 = mem0[rd0[4:0]];
  assign fifo_rdata1 = mem1[rd1[4:0]];

  fifo_serial_tx #(.CLKS_PER_BIT(8), .PARITY_EN(1'b0), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .tx_en(tx_en0), .fifo_empty(fifo_empty0),
    .fifo_rdata(fifo_rdata0), .fifo_r_enable(fifo_r_enable0),
    .serial_out(serial_out0), .busy(busy0), .frame_done(frame_done0),
    .bytes_sent(bytes_sent0)
  );

  fifo_serial_tx #(.CLKS_PER_BIT(8), .PARITY_EN(1'b1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en1), .fifo_empty(fifo_empty1),
    .fifo_rdata(fifo_rdata1), .fifo_r_enable(fifo_r_enable1),
    .serial_out(serial_out1), .busy(busy1), .frame_done(frame_done1),
    .bytes_sent(bytes_sent1)
  );

  // FIFO read side: pop on the edge where the pop strobe is high.
  always @(posedge clk) begin
    if (flush0) begin
      rd0 <= wr0;
    end else if (fifo_r_enable0) begin
      rd0   <= rd0 + 6'd1;
      pops0 <= pops0 + 1;
    end
    if (fifo_r_enable1) begin
      rd1   <= rd1 + 6'd1;
      pops1 <= pops1 + 1;
    end
  end

  always @(negedge clk) begin
    if (frame_done1) begin
      fd1_cnt <= fd1_cnt + 1;
      if (fd1_prev) fd1_dbl <= fd1_dbl + 1;
    end
    fd1_prev <= frame_done1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [7:0] b);
    mem0[wr0[4:0]] = b;
    wr0 = wr0 + 6'd1;
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wr1[4:0]] = b;
    wr1 = wr1 + 6'd1;
  endtask

  // One 80-cycle frame on dut0; fr holds line levels bit0=start .. bit9=stop.
  task automatic run_frame0(input string tag, input logic [9:0] fr);
    for (int k = 1; k <= 80; k++) begin
      tick();
      check($sformatf("%s_serial_c%0d", tag, k), 32'(serial_out0), 32'(fr[(k-1)/8]));
      check($sformatf("%s_done_c%0d", tag, k), 32'(frame_done0), 32'(k == 80));
      check($sformatf("%s_busy_c%0d", tag, k), 32'(busy0), 1);
      check($sformatf("%s_ren_c%0d", tag, k), 32'(fifo_r_enable0), 0);
    end
  endtask

  initial begin
    logic [21:0] fr1;
    bit done;

    rst = 1'b1; tx_en0 = 1'b0; tx_en1 = 1'b0; flush0 = 1'b0;
    wr0 = '0; wr1 = '0;

    // Reset with a byte waiting and transmit disabled
    push0(8'h3C);
    repeat (3) tick();
    check("rst_serial0", 32'(serial_out0), 1);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_done0", 32'(frame_done0), 0);
    check("rst_bytes0", 32'(bytes_sent0), 0);
    check("rst_ren0", 32'(fifo_r_enable0), 0);
    check("rst_serial1", 32'(serial_out1), 1);
    check("rst_busy1", 32'(busy1), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("txen0_ren", 32'(fifo_r_enable0), 0);
    end
    check("txen0_pops", 32'(pops0), 0);
    check("txen0_busy", 32'(busy0), 0);

    // Single byte 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1
    flush0 = 1'b1; tick(); flush0 = 1'b0;
    push0(8'hA5);
    tx_en0 = 1'b1;
    #1;
    check("a5_ren_launch", 32'(fifo_r_enable0), 1);
    run_frame0("a5", 10'b1101001010);
    tick();
    check("a5_busy_after", 32'(busy0), 0);
    check("a5_bytes", 32'(bytes_sent0), 1);
    check("a5_serial_idle", 32'(serial_out0), 1);
    check("a5_done_after", 32'(frame_done0), 0);
    check("a5_pops", 32'(pops0), 1);

    // Parity: 0xA5 (parity 0) then 0x01 (parity 1), back-to-back
    fr1 = {11'b11000000010, 11'b10101001010};
    push1(8'hA5);
    push1(8'h01);
    tx_en1 = 1'b1;
    #1;
    check("par_ren_launch", 32'(fifo_r_enable1), 1);
    for (int k = 1; k <= 176; k++) begin
      tick();
      check($sformatf("par_serial_c%0d", k), 32'(serial_out1), 32'(fr1[(k-1)/8]));
      check($sformatf("par_busy_c%0d", k), 32'(busy1), 1);
      check($sformatf("par_done_c%0d", k), 32'(frame_done1), 32'(k == 88 || k == 176));
      check($sformatf("par_ren_c%0d", k), 32'(fifo_r_enable1), 32'(k == 88));
    end
    tick();
    check("par_busy_after", 32'(busy1), 0);
    check("par_bytes", 32'(bytes_sent1), 2);
    check("par_pops", 32'(pops1), 2);

    // 15 more bytes on the 4-bit counter: 17 total wraps to 1
    for (int i = 0; i < 15; i++) push1(8'h10 + 8'(i));
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      tick();
      if (!busy1 && fifo_empty1) done = 1'b1;
    end
    check("wrap_timeout", 32'(done), 1);
    check("wrap_bytes", 32'(bytes_sent1), 1);
    check("wrap_done_count", 32'(fd1_cnt), 17);
    check("wrap_done_double", 32'(fd1_dbl), 0);
    check("wrap_pops", 32'(pops1), 17);

    // tx_en dropped mid-DATA: frame completes, no further pops
    push0(8'h11); push0(8'h22); push0(8'h33);
    #1;
    check("txoff_ren_launch", 32'(fifo_r_enable0), 1);
    repeat (20) tick();
    tx_en0 = 1'b0;
    repeat (60) tick();
    check("txoff_done", 32'(frame_done0), 1);
    check("txoff_ren_end", 32'(fifo_r_enable0), 0);
    check("txoff_busy_end", 32'(busy0), 1);
    tick();
    check("txoff_busy_after", 32'(busy0), 0);
    check("txoff_bytes", 32'(bytes_sent0), 2);
    repeat (20) tick();
    check("txoff_busy_idle", 32'(busy0), 0);
    check("txoff_pops", 32'(pops0), 2);
    check("txoff_fifo_level", 32'(wr0 - rd0), 2);
    check("txoff_fifo_head", 32'(fifo_rdata0), 32'h22);
    check("txoff_serial", 32'(serial_out0), 1);

    // Reset during data bit 4 of 0xFF; next byte 0x5A follows release
    flush0 = 1'b1; tick(); flush0 = 1'b0;
    push0(8'hFF); push0(8'h5A);
    tx_en0 = 1'b1;
    #1;
    check("abort_ren_launch", 32'(fifo_r_enable0), 1);
    repeat (44) tick();
    check("abort_serial_bit4", 32'(serial_out0), 1);
    check("abort_busy_bit4", 32'(busy0), 1);
    rst = 1'b1;
    tick();
    check("abort_serial", 32'(serial_out0), 1);
    check("abort_busy", 32'(busy0), 0);
    check("abort_done", 32'(frame_done0), 0);
    check("abort_bytes", 32'(bytes_sent0), 0);
    check("abort_ren_in_rst", 32'(fifo_r_enable0), 0);
    check("abort_fifo_level", 32'(wr0 - rd0), 1);
    check("abort_fifo_head", 32'(fifo_rdata0), 32'h5A);
    rst = 1'b0;
    #1;
    check("abort_ren_release", 32'(fifo_r_enable0), 1);
    run_frame0("5a", 10'b1010110100);
    tick();
    check("5a_bytes", 32'(bytes_sent0), 1);
    check("5a_busy_after", 32'(busy0), 0);
    check("5a_pops", 32'(pops0), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
